// File: rtl/anomaly_rate_monitor.sv
// Sliding-window anomaly counter with hysteretic alarm, sticky interrupt and
// a saturating lifetime anomaly total.
module anomaly_rate_monitor #(
   parameter  int unsigned WINDOW      = 32,
   parameter  int unsigned HIGH_THRESH = 8,
   parameter  int unsigned LOW_THRESH  = 4,
   parameter  int unsigned COOLDOWN    = 16,
   parameter  int unsigned TOTAL_W     = 16,
   localparam int unsigned CW          = $clog2(WINDOW + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               sample_valid,
   input  logic               anomaly_detected,
   input  logic               alarm_ack,
   input  logic               soft_clear,
   output logic [CW-1:0]      anomaly_count,
   output logic               window_full,
   output logic               alarm_active,
   output logic               alarm_irq,
   output logic [TOTAL_W-1:0] total_anomalies
);

   localparam int unsigned TW = $clog2(COOLDOWN + 1);

   localparam logic [1:0] S_WARMUP   = 2'd0;
   localparam logic [1:0] S_NORMAL   = 2'd1;
   localparam logic [1:0] S_ALERT    = 2'd2;
   localparam logic [1:0] S_COOLDOWN = 2'd3;

   localparam logic [CW-1:0] C_HIGH   = CW'(HIGH_THRESH);
   localparam logic [CW-1:0] C_LOW    = CW'(LOW_THRESH);
   localparam logic [CW-1:0] C_WIN_M1 = CW'(WINDOW - 1);
   localparam logic [TW-1:0] C_COOL   = TW'(COOLDOWN);

   logic [WINDOW-1:0]  r_hist;
   logic [CW-1:0]      r_count;
   logic [CW-1:0]      r_seen;
   logic               r_full;
   logic [1:0]         r_state;
   logic [TW-1:0]      r_timer;
   logic               r_irq;
   logic [TOTAL_W-1:0] r_total;

   logic               w_evict;
   logic [CW-1:0]      w_count_nxt;
   logic               w_hi;
   logic               w_lo;
   logic [1:0]         w_state_nxt;
   logic [TW-1:0]      w_timer_nxt;
   logic               w_enter_alert;

   // The oldest bit only leaves the window once WINDOW samples have been seen.
   assign w_evict     = r_full & r_hist[WINDOW-1];
   assign w_count_nxt = r_count + CW'(anomaly_detected) - CW'(w_evict);
   assign w_hi        = (r_count >= C_HIGH);
   assign w_lo        = (r_count <= C_LOW);

   always_comb begin
      w_state_nxt   = r_state;
      w_timer_nxt   = r_timer;
      w_enter_alert = 1'b0;
      case (r_state)
         S_WARMUP: begin
            if (r_full) begin
               if (w_hi) w_enter_alert = 1'b1;
               else      w_state_nxt   = S_NORMAL;
            end
         end
         S_NORMAL: begin
            if (w_hi) w_enter_alert = 1'b1;
         end
         S_ALERT: begin
            if (w_lo) begin
               w_state_nxt = S_COOLDOWN;
               w_timer_nxt = C_COOL;
            end
         end
         S_COOLDOWN: begin
            if (w_hi) begin
               w_enter_alert = 1'b1;
            end else if (sample_valid) begin
               w_timer_nxt = r_timer - TW'(1);
               if (r_timer <= TW'(1)) w_state_nxt = S_NORMAL;
            end
         end
         default: w_state_nxt = S_WARMUP;
      endcase
      if (w_enter_alert) w_state_nxt = S_ALERT;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hist  <= '0;
         r_count <= '0;
         r_seen  <= '0;
         r_full  <= 1'b0;
         r_state <= S_WARMUP;
         r_timer <= '0;
         r_irq   <= 1'b0;
         r_total <= '0;
      end else if (soft_clear) begin
         r_hist  <= '0;
         r_count <= '0;
         r_seen  <= '0;
         r_full  <= 1'b0;
         r_state <= S_WARMUP;
         r_timer <= '0;
         r_irq   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
         if (w_enter_alert)  r_irq <= 1'b1;
         else if (alarm_ack) r_irq <= 1'b0;
         if (sample_valid) begin
            r_hist  <= {r_hist[WINDOW-2:0], anomaly_detected};
            r_count <= w_count_nxt;
            if (!r_full) begin
               r_seen <= r_seen + CW'(1);
               r_full <= (r_seen == C_WIN_M1);
            end
            if (anomaly_detected && (r_total != '1)) r_total <= r_total + TOTAL_W'(1);
         end
      end
   end

   assign anomaly_count   = r_count;
   assign window_full     = r_full;
   assign alarm_active    = (r_state == S_ALERT) || (r_state == S_COOLDOWN);
   assign alarm_irq       = r_irq;
   assign total_anomalies = r_total;

endmodule
